hazard_fwd_ctrl: RTL and testbench

Pipeline hazard controller for the five-stage MIPS core. It tracks destination register and remaining result latency (Tnew) for instructions in E, M and W. From that it drives the 2-bit selects of the 3:1 forwarding muxes in D (branch compare) and E (ALU operands), and asserts the D-stage stall. It also owns the multiply/divide busy counter that stalls HI/LO consumers.

---
 rtl/hazard_fwd_ctrl_pkg.sv | 41 ++++
 rtl/hazard_fwd_ctrl_md_busy_cnt.sv | 39 +++
 rtl/hazard_fwd_ctrl.sv | 78 +++++++
 tb/tb_hazard_fwd_ctrl.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/hazard_fwd_ctrl_pkg.sv
// Shared encodings, stage-entry record and match helpers for the hazard/forwarding controller.
package hazard_fwd_ctrl_pkg;

    localparam logic [1:0] FWD_RF    = 2'b00;
    localparam logic [1:0] FWD_M     = 2'b01;
    localparam logic [1:0] FWD_W     = 2'b10;
    localparam logic [1:0] TUSE_NONE = 2'd3;

    typedef enum logic [1:0] {
        MD_NONE = 2'b00,
        MD_MULT = 2'b01,
        MD_DIV  = 2'b10
    } md_op_e;

    typedef struct packed {
        logic [4:0] rs;
        logic [4:0] rt;
        logic [4:0] dst;
        logic [1:0] tnew;
    } stage_t;

    // M wins over W; a result still in flight in M is not yet forwardable.
    function automatic logic [1:0] fwd_sel(input logic [4:0] r, input logic [4:0] m_dst,
                                           input logic [1:0] m_tnew, input logic [4:0] w_dst);
        if (r != 5'd0 && m_dst == r && m_tnew == 2'd0)
            return FWD_M;
        else if (r != 5'd0 && w_dst == r)
            return FWD_W;
        else
            return FWD_RF;
    endfunction

    function automatic logic src_stall(input logic [4:0] r, input logic [1:0] tuse,
                                       input logic [4:0] e_dst, input logic [1:0] e_tnew,
                                       input logic [4:0] m_dst, input logic [1:0] m_tnew);
        if (r == 5'd0 || tuse == TUSE_NONE)
            return 1'b0;
        return (e_dst == r && e_tnew > tuse) || (m_dst == r && m_tnew > tuse);
    endfunction

endpackage

// File: rtl/hazard_fwd_ctrl_md_busy_cnt.sv
// Multiply/divide busy counter: loads the op latency when an MD op leaves D, then counts down.
module md_busy_cnt
    import hazard_fwd_ctrl_pkg::*;
#(
    parameter int MULT_CYC = 5,
    parameter int DIV_CYC  = 10
) (
    input  logic clk,
    input  logic reset_n,
    input  logic start_mult_i,
    input  logic start_div_i,
    output logic busy_o
);

    localparam int MAXC = (MULT_CYC > DIV_CYC) ? MULT_CYC : DIV_CYC;
    localparam int CW   = $clog2(MAXC + 1);

    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (start_mult_i)
            cnt_d = CW'(MULT_CYC);
        else if (start_div_i)
            cnt_d = CW'(DIV_CYC);
        else if (cnt_q != '0)
            cnt_d = cnt_q - CW'(1);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            cnt_q <= '0;
        else
            cnt_q <= cnt_d;
    end

    assign busy_o = (cnt_q != '0);

endmodule

// File: rtl/hazard_fwd_ctrl.sv
// Five-stage pipeline hazard controller: tracks E/M/W destinations and Tnew, drives
// D/E forwarding selects, the D-stage stall and the MD busy counter.
module hazard_fwd_ctrl
    import hazard_fwd_ctrl_pkg::*;
#(
    parameter int MD_MULT_CYC = 5,
    parameter int MD_DIV_CYC  = 10
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [4:0] d_rs,
    input  logic [4:0] d_rt,
    input  logic [1:0] d_tuse_rs,
    input  logic [1:0] d_tuse_rt,
    input  logic [4:0] d_dst,
    input  logic [1:0] d_tnew,
    input  logic [1:0] d_md_op,
    input  logic       d_md_use,
    output logic       stall,
    output logic [1:0] d_fwd_rs,
    output logic [1:0] d_fwd_rt,
    output logic [1:0] e_fwd_rs,
    output logic [1:0] e_fwd_rt,
    output logic       md_busy
);

    stage_t     e_q, e_d;
    logic [4:0] m_dst_q, m_dst_d;
    logic [1:0] m_tnew_q, m_tnew_d;
    logic [4:0] w_dst_q, w_dst_d;
    logic       data_stall;
    logic       md_start_ok;

    assign data_stall = src_stall(d_rs, d_tuse_rs, e_q.dst, e_q.tnew, m_dst_q, m_tnew_q)
                      | src_stall(d_rt, d_tuse_rt, e_q.dst, e_q.tnew, m_dst_q, m_tnew_q);
    assign stall = data_stall | (d_md_use & md_busy);

    assign d_fwd_rs = fwd_sel(d_rs,   m_dst_q, m_tnew_q, w_dst_q);
    assign d_fwd_rt = fwd_sel(d_rt,   m_dst_q, m_tnew_q, w_dst_q);
    assign e_fwd_rs = fwd_sel(e_q.rs, m_dst_q, m_tnew_q, w_dst_q);
    assign e_fwd_rt = fwd_sel(e_q.rt, m_dst_q, m_tnew_q, w_dst_q);

    // A stalled D instruction becomes a bubble in E; M and W keep draining.
    always_comb begin
        e_d      = stall ? '0 : '{rs: d_rs, rt: d_rt, dst: d_dst, tnew: d_tnew};
        m_dst_d  = e_q.dst;
        m_tnew_d = (e_q.tnew == 2'd0) ? 2'd0 : e_q.tnew - 2'd1;
        w_dst_d  = m_dst_q;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            e_q      <= '0;
            m_dst_q  <= '0;
            m_tnew_q <= '0;
            w_dst_q  <= '0;
        end else begin
            e_q      <= e_d;
            m_dst_q  <= m_dst_d;
            m_tnew_q <= m_tnew_d;
            w_dst_q  <= w_dst_d;
        end
    end

    assign md_start_ok = ~stall;

    md_busy_cnt #(
        .MULT_CYC(MD_MULT_CYC),
        .DIV_CYC (MD_DIV_CYC)
    ) u_md_busy_cnt (
        .clk         (clk),
        .reset_n     (reset_n),
        .start_mult_i(md_start_ok && d_md_op == MD_MULT),
        .start_div_i (md_start_ok && d_md_op == MD_DIV),
        .busy_o      (md_busy)
    );

endmodule

// File: tb/tb_hazard_fwd_ctrl.sv
// Directed bench for hazard_fwd_ctrl with a time-stamped pipeline model checked every cycle.
module tb_hazard_fwd_ctrl;

    localparam int MULT_N = 5;
    localparam int DIV_N  = 10;

    logic       clk, reset_n;
    logic [4:0] d_rs, d_rt, d_dst;
    logic [1:0] d_tuse_rs, d_tuse_rt, d_tnew, d_md_op;
    logic       d_md_use;
    logic       stall, md_busy;
    logic [1:0] d_fwd_rs, d_fwd_rt, e_fwd_rs, e_fwd_rt;

    int n_checks = 0;
    int n_fail   = 0;

    hazard_fwd_ctrl #(.MD_MULT_CYC(MULT_N), .MD_DIV_CYC(DIV_N)) dut (
        .clk(clk), .reset_n(reset_n),
        .d_rs(d_rs), .d_rt(d_rt), .d_tuse_rs(d_tuse_rs), .d_tuse_rt(d_tuse_rt),
        .d_dst(d_dst), .d_tnew(d_tnew), .d_md_op(d_md_op), .d_md_use(d_md_use),
        .stall(stall), .d_fwd_rs(d_fwd_rs), .d_fwd_rt(d_fwd_rt),
        .e_fwd_rs(e_fwd_rs), .e_fwd_rt(e_fwd_rt), .md_busy(md_busy)
    );

    // clock / reset
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Model: each instruction that entered E is remembered by age (0=E, 1=M, 2=W);
    // its remaining latency is its entry Tnew minus its age, floored at zero.
    typedef struct {
        logic [4:0] rs;
        logic [4:0] rt;
        logic [4:0] dst;
        int         tnew;
    } ent_t;

    ent_t hist[$];
    int   cyc      = 0;
    int   md_until = -1;

    function automatic ent_t at(int a);
        ent_t z;
        z = '{rs: 5'd0, rt: 5'd0, dst: 5'd0, tnew: 0};
        if (a < hist.size()) return hist[a];
        return z;
    endfunction

    function automatic int remaining(int a);
        ent_t e;
        e = at(a);
        return (e.tnew > a) ? e.tnew - a : 0;
    endfunction

    function automatic logic [1:0] m_fwd(logic [4:0] r);
        if (r == 5'd0) return 2'b00;
        if (at(1).dst == r && remaining(1) == 0) return 2'b01;
        if (at(2).dst == r) return 2'b10;
        return 2'b00;
    endfunction

    function automatic logic m_src_stall(logic [4:0] r, logic [1:0] tuse);
        if (r == 5'd0 || tuse == 2'd3) return 1'b0;
        for (int a = 0; a < 2; a++)
            if (at(a).dst == r && remaining(a) > int'(tuse)) return 1'b1;
        return 1'b0;
    endfunction

    function automatic logic m_md_busy();
        return cyc <= md_until;
    endfunction

    function automatic logic m_stall();
        return m_src_stall(d_rs, d_tuse_rs) || m_src_stall(d_rt, d_tuse_rt) ||
               (d_md_use && m_md_busy());
    endfunction

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            hist.delete();
            md_until = -1;
        end else begin
            ent_t n;
            logic st;
            st = m_stall();
            if (!st && d_md_op == 2'b01) md_until = cyc + MULT_N;
            if (!st && d_md_op == 2'b10) md_until = cyc + DIV_N;
            if (st) n = '{rs: 5'd0, rt: 5'd0, dst: 5'd0, tnew: 0};
            else    n = '{rs: d_rs, rt: d_rt, dst: d_dst, tnew: int'(d_tnew)};
            hist.push_front(n);
            if (hist.size() > 3) void'(hist.pop_back());
        end
        if (clk) cyc++;
    end

    // scoreboard
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        check("stall",    32'(stall),    32'(m_stall()));
        check("d_fwd_rs", 32'(d_fwd_rs), 32'(m_fwd(d_rs)));
        check("d_fwd_rt", 32'(d_fwd_rt), 32'(m_fwd(d_rt)));
        check("e_fwd_rs", 32'(e_fwd_rs), 32'(m_fwd(at(0).rs)));
        check("e_fwd_rt", 32'(e_fwd_rt), 32'(m_fwd(at(0).rt)));
        check("md_busy",  32'(md_busy),  32'(m_md_busy()));
    end

    // drivers
    task automatic set_d(input logic [4:0] rs, input logic [4:0] rt, input logic [1:0] trs,
                         input logic [1:0] trt, input logic [4:0] dst, input logic [1:0] tnew,
                         input logic [1:0] mdop, input logic mduse);
        d_rs = rs; d_rt = rt; d_tuse_rs = trs; d_tuse_rt = trt;
        d_dst = dst; d_tnew = tnew; d_md_op = mdop; d_md_use = mduse;
    endtask

    task automatic nop();
        set_d(5'd0, 5'd0, 2'd3, 2'd3, 5'd0, 2'd0, 2'b00, 1'b0);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic flush();
        nop();
        repeat (4) tick();
    endtask

    initial begin
        reset_n = 1'b0;
        // reset held while D requests a load-use hazard, forwarding and an MD start
        set_d(5'd1, 5'd2, 2'd0, 2'd0, 5'd1, 2'd2, 2'b01, 1'b1);
        #1;
        repeat (3) tick();
        #2;
        check("rst_stall", 32'(stall), 32'd0);
        check("rst_dfwd",  32'({d_fwd_rs, d_fwd_rt, e_fwd_rs, e_fwd_rt}), 32'd0);
        check("rst_busy",  32'(md_busy), 32'd0);
        nop();
        tick();
        reset_n = 1'b1;
        tick();

        // div, then async reset mid-count
        set_d(5'd0, 5'd0, 2'd3, 2'd3, 5'd0, 2'd0, 2'b10, 1'b1);
        tick();
        nop();
        repeat (3) tick();
        #2;
        check("div_busy_pre", 32'(md_busy), 32'd1);
        reset_n = 1'b0;
        #1;
        check("arst_busy",  32'(md_busy), 32'd0);
        check("arst_stall", 32'(stall), 32'd0);
        tick();
        reset_n = 1'b1;
        tick();
        set_d(5'd0, 5'd0, 2'd3, 2'd3, 5'd8, 2'd1, 2'b00, 1'b1);
        #2;
        check("post_rst_mfhi_stall", 32'(stall), 32'd0);
        check("post_rst_busy",       32'(md_busy), 32'd0);
        tick();
        flush();

        // ALU dependency: addu $1 then addu $3,$1,$2
        set_d(5'd0, 5'd0, 2'd3, 2'd3, 5'd1, 2'd1, 2'b00, 1'b0);
        tick();
        set_d(5'd1, 5'd2, 2'd1, 2'd1, 5'd3, 2'd1, 2'b00, 1'b0);
        #2;
        check("alu_stall", 32'(stall), 32'd0);
        check("alu_dfwd",  32'(d_fwd_rs), 32'd0);
        tick();
        nop();
        #2;
        check("alu_efwd_rs", 32'(e_fwd_rs), 32'd1);
        check("alu_efwd_rt", 32'(e_fwd_rt), 32'd0);
        tick();
        flush();

        // load-use into branch: lw $2 then beq $2
        set_d(5'd0, 5'd0, 2'd3, 2'd3, 5'd2, 2'd2, 2'b00, 1'b0);
        tick();
        set_d(5'd2, 5'd0, 2'd0, 2'd3, 5'd0, 2'd0, 2'b00, 1'b0);
        #2;
        check("lu_stall1", 32'(stall), 32'd1);
        tick();
        #2;
        check("lu_stall2", 32'(stall), 32'd1);
        tick();
        #2;
        check("lu_stall3", 32'(stall), 32'd0);
        check("lu_dfwd",   32'(d_fwd_rs), 32'd2);
        tick();
        flush();

        // writer of $0 then reader of $0
        set_d(5'd0, 5'd0, 2'd3, 2'd3, 5'd0, 2'd2, 2'b00, 1'b0);
        tick();
        set_d(5'd0, 5'd0, 2'd0, 2'd0, 5'd4, 2'd1, 2'b00, 1'b0);
        #2;
        check("r0_stall", 32'(stall), 32'd0);
        check("r0_dfwd",  32'({d_fwd_rs, d_fwd_rt}), 32'd0);
        tick();
        nop();
        tick();
        #2;
        check("r0_efwd",  32'({e_fwd_rs, e_fwd_rt}), 32'd0);
        tick();
        flush();

        // priority: $5 written twice back to back, consumer reads rt=$5
        set_d(5'd0, 5'd0, 2'd3, 2'd3, 5'd5, 2'd1, 2'b00, 1'b0);
        tick();
        set_d(5'd0, 5'd0, 2'd3, 2'd3, 5'd5, 2'd1, 2'b00, 1'b0);
        tick();
        set_d(5'd0, 5'd5, 2'd3, 2'd1, 5'd6, 2'd1, 2'b00, 1'b0);
        #2;
        check("pri_stall", 32'(stall), 32'd0);
        check("pri_dfwd",  32'(d_fwd_rt), 32'd1);
        tick();
        nop();
        #2;
        check("pri_efwd",  32'(e_fwd_rt), 32'd1);
        tick();
        flush();

        // mult then mfhi, then div then mfhi
        for (int k = 0; k < 2; k++) begin
            int n;
            n = (k == 0) ? MULT_N : DIV_N;
            set_d(5'd0, 5'd0, 2'd3, 2'd3, 5'd0, 2'd0, (k == 0) ? 2'b01 : 2'b10, 1'b1);
            #2;
            check("md_start_stall", 32'(stall), 32'd0);
            tick();
            set_d(5'd0, 5'd0, 2'd3, 2'd3, 5'd8, 2'd1, 2'b00, 1'b1);
            for (int c = 0; c < n; c++) begin
                #2;
                check("md_hold_stall", 32'(stall), 32'd1);
                check("md_hold_busy",  32'(md_busy), 32'd1);
                tick();
            end
            #2;
            check("md_done_stall", 32'(stall), 32'd0);
            check("md_done_busy",  32'(md_busy), 32'd0);
            tick();
            flush();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
